// File: rtl/pipelined_addsub_if.sv
// Streaming operand/result bundle for pipelined_addsub.
// The master drives operands and out_ready; the slave (the adder) drives results and in_ready.
interface pipelined_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits are split into STAGES registered
// carry-ripple slices, with valid/ready streaming and a single global stall.
module pipelined_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic              clk,
  input  logic              rst,
  pipelined_addsub_if.slave bus
);
  localparam int SW = WIDTH / STAGES;

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // in_ready looks only at the output side, so in_valid can never loop back into it.
  assign stall        = bus.out_valid && !bus.out_ready;
  assign bus.in_ready = !stall;

  // Subtraction is A + ~B + ~borrow_in, so both modes share the same adder.
  assign b_eff = bus.sub ? ~bus.b   : bus.b;
  assign c_eff = bus.sub ? ~bus.cin : bus.cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * SW;
    localparam int REM = WIDTH - LO;

    logic [REM-1:0]     src_a;
    logic [REM-1:0]     src_b;
    logic               src_c;
    logic               valid_d;
    logic [SW-1:0]      slice_sum;
    logic [SW:0]        chain;
    logic [LO+SW-1:0]   sum_d;
    logic [LO+SW-1:0]   sum_q;
    logic               valid_q;
    logic               carry_q;

    if (k == 0) begin : g_src
      assign src_a   = bus.a;
      assign src_b   = b_eff;
      assign src_c   = c_eff;
      assign valid_d = bus.in_valid;
      assign sum_d   = slice_sum;
    end else begin : g_src
      assign src_a   = g_stage[k-1].g_skew.a_q;
      assign src_b   = g_stage[k-1].g_skew.b_q;
      assign src_c   = g_stage[k-1].carry_q;
      assign valid_d = g_stage[k-1].valid_q;
      assign sum_d   = {slice_sum, g_stage[k-1].sum_q};
    end

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
      slice_sum = '0;
      chain     = '0;
      chain[0]  = src_c;
      for (int j = 0; j < SW; j++) begin
        slice_sum[j] = src_a[j] ^ src_b[j] ^ chain[j];
        chain[j+1]   = (src_a[j] & src_b[j]) | ((src_a[j] ^ src_b[j]) & chain[j]);
      end
    end

    // NOTE: non-blocking assignments make every stage sample its predecessor's pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        sum_q   <= '0;
        carry_q <= 1'b0;
      end else if (!stall) begin
        valid_q <= valid_d;
        sum_q   <= sum_d;
        carry_q <= chain[SW];
      end
    end

    if (k < STAGES - 1) begin : g_skew
      // Upper operand slices travel alongside the partial sum until their stage adds them.
      logic [REM-SW-1:0] a_q;
      logic [REM-SW-1:0] b_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall) begin
          a_q <= src_a[REM-1:SW];
          b_q <= src_b[REM-1:SW];
        end
      end
    end else begin : g_msb
      // Only the last slice contains the MSB cell, so only it holds the carry into that cell.
      logic cmsb_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cmsb_q <= 1'b0;
        end else if (!stall) begin
          cmsb_q <= chain[SW-1];
        end
      end
    end
  end

  assign bus.out_valid = g_stage[STAGES-1].valid_q;
  assign bus.sum       = g_stage[STAGES-1].sum_q;
  assign bus.cout      = g_stage[STAGES-1].carry_q;
  assign bus.overflow  = g_stage[STAGES-1].g_msb.cmsb_q ^ g_stage[STAGES-1].carry_q;

endmodule
